// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: streams instruction words then packed 64-bit data words into
// the CPU external memory ports, then enables the CPU until stopped.
module cpu_mem_loader #(
  parameter logic [63:0] IMEM_BASE = 64'h0,
  parameter logic [63:0] DMEM_BASE = 64'h0,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] imem_count,
  input  logic [CNT_W-1:0] dmem_count,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  output logic             cpu_enable,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D_LO, LOAD_D_HI, RUN} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] icnt, dcnt, i_idx, d_idx;
  logic [31:0] lo;
  logic hs, en_nx;
  assign in_ready  = state == LOAD_I || state == LOAD_D_LO || state == LOAD_D_HI;
  assign hs        = in_valid && in_ready;
  assign ren_ext   = 1'b0;
  assign ren_ext_2 = 1'b0;
  // Enable lags the final write strobe by a cycle so it never overlaps a write.
  assign en_nx = (state == RUN && !stop) ||
                 (state == IDLE && start && ~|imem_count && ~|dmem_count);
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = |imem_count ? LOAD_I : |dmem_count ? LOAD_D_LO : RUN;
      LOAD_I:    if (hs && i_idx == icnt - CNT_W'(1)) state_nx = |dcnt ? LOAD_D_LO : RUN;
      LOAD_D_LO: if (hs) state_nx = LOAD_D_HI;
      LOAD_D_HI: if (hs) state_nx = d_idx == dcnt - CNT_W'(1) ? RUN : LOAD_D_LO;
      RUN:       if (stop) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      icnt        <= '0;
      dcnt        <= '0;
      i_idx       <= '0;
      d_idx       <= '0;
      lo          <= '0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      cpu_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      wen_ext    <= state == LOAD_I && hs;
      wen_ext_2  <= state == LOAD_D_HI && hs;
      cpu_enable <= en_nx;
      done       <= en_nx && !cpu_enable;
      busy       <= state_nx != IDLE;
      if (state == IDLE && start) begin
        icnt  <= imem_count;
        dcnt  <= dmem_count;
        i_idx <= '0;
        d_idx <= '0;
      end
      if (state == LOAD_I && hs) begin
        addr_ext  <= IMEM_BASE + (64'(i_idx) << 2);
        wdata_ext <= in_data;
        i_idx     <= i_idx + CNT_W'(1);
      end
      if (state == LOAD_D_LO && hs) lo <= in_data;
      if (state == LOAD_D_HI && hs) begin
        addr_ext_2  <= DMEM_BASE + (64'(d_idx) << 3);
        wdata_ext_2 <= {in_data, lo};
        d_idx       <= d_idx + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb_cpu_mem_loader: directed loads with a write scoreboard checked on every strobe.
module tb_cpu_mem_loader;
  logic clk = 1'b0, arst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [15:0] imem_count = '0, dmem_count = '0;
  logic in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy, done;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] wdata_ext;
  int total = 0, bad = 0;
  typedef struct {logic dm; logic [63:0] addr; logic [63:0] data;} wr_t;
  wr_t q[$];
  wr_t e;

  cpu_mem_loader #(.IMEM_BASE(64'h0), .DMEM_BASE(64'h100), .CNT_W(16)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .stop(stop),
    .imem_count(imem_count), .dmem_count(dmem_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .cpu_enable(cpu_enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the oldest expected write of its memory kind.
  always @(negedge clk) begin
    if (wen_ext || wen_ext_2) check("en_excl", {63'd0, cpu_enable}, 64'd0);
    if (wen_ext) begin
      check("sb_has_i", {63'd0, q.size() != 0}, 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("i_kind", {63'd0, e.dm}, 64'd0);
        check("i_addr", addr_ext, e.addr);
        check("i_data", {32'd0, wdata_ext}, e.data);
      end
    end
    if (wen_ext_2) begin
      check("sb_has_d", {63'd0, q.size() != 0}, 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("d_kind", {63'd0, e.dm}, 64'd1);
        check("d_addr", addr_ext_2, e.addr);
        check("d_data", wdata_ext_2, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int ic, input int dc);
    imem_count = 16'(ic);
    dmem_count = 16'(dc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    in_data = w;
    in_valid = 1'b1;
    @(negedge clk);
    check("ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_i(input int idx, input logic [31:0] w);
    q.push_back('{dm: 1'b0, addr: 64'(idx) * 64'd4, data: {32'd0, w}});
  endtask

  task automatic push_d(input int idx, input logic [31:0] hi, input logic [31:0] lo);
    q.push_back('{dm: 1'b1, addr: 64'h100 + 64'(idx) * 64'd8, data: {hi, lo}});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_wen"}, {62'd0, wen_ext, wen_ext_2}, 64'd0);
    check({tag, "_ren"}, {62'd0, ren_ext, ren_ext_2}, 64'd0);
    check({tag, "_addr_i"}, addr_ext, 64'd0);
    check({tag, "_addr_d"}, addr_ext_2, 64'd0);
    check({tag, "_wdata_i"}, {32'd0, wdata_ext}, 64'd0);
    check({tag, "_wdata_d"}, wdata_ext_2, 64'd0);
    check({tag, "_ctl"}, {61'd0, cpu_enable, busy, done}, 64'd0);
  endtask

  // Expect the first RUN cycle (enable + done) one cycle after the final strobe.
  task automatic expect_run(input string tag);
    @(negedge clk);
    check({tag, "_pre_en"}, {62'd0, cpu_enable, done}, 64'd0);
    tick();
    @(negedge clk);
    check({tag, "_run"}, {61'd0, cpu_enable, done, busy}, 64'd7);
    tick();
    @(negedge clk);
    check({tag, "_done_1cyc"}, {62'd0, cpu_enable, done}, 64'd2);
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    check({tag, "_stopped"}, {62'd0, cpu_enable, busy}, 64'd0);
  endtask

  initial begin
    #2;
    check_reset("rst");
    tick();
    tick();
    arst_n = 1'b1;
    // three instruction words back to back
    start_load(3, 0);
    push_i(0, 32'h00000013);
    send(32'h00000013);
    push_i(1, 32'h00100093);
    send(32'h00100093);
    push_i(2, 32'h00208113);
    send(32'h00208113);
    expect_run("t1");
    do_stop("t1");
    // one instruction plus two packed data words
    start_load(1, 2);
    push_i(0, 32'h13);
    send(32'h13);
    send(32'hDEADBEEF);
    push_d(0, 32'h01234567, 32'hDEADBEEF);
    send(32'h01234567);
    send(32'h11111111);
    push_d(1, 32'h22222222, 32'h11111111);
    send(32'h22222222);
    expect_run("t2");
    do_stop("t2");
    // in_valid 1,0,0,1 stalls the instruction stream
    start_load(2, 0);
    push_i(0, 32'hAAAA0001);
    send(32'hAAAA0001);
    tick();
    @(negedge clk);
    check("stall_wen", {63'd0, wen_ext}, 64'd0);
    check("stall_hold", {addr_ext[31:0], wdata_ext}, {32'd0, 32'hAAAA0001});
    check("stall_ready", {63'd0, in_ready}, 64'd1);
    tick();
    push_i(1, 32'hBBBB0002);
    send(32'hBBBB0002);
    expect_run("t3");
    do_stop("t3");
    // both counts zero: straight to RUN
    start_load(0, 0);
    @(negedge clk);
    check("zero_run", {60'd0, cpu_enable, done, busy, wen_ext | wen_ext_2}, 64'hE);
    tick();
    @(negedge clk);
    check("zero_done_1cyc", {62'd0, cpu_enable, done}, 64'd2);
    do_stop("t4");
    // async reset after 2 of 4 words, then reload from base
    start_load(4, 0);
    push_i(0, 32'h0C0C0001);
    send(32'h0C0C0001);
    push_i(1, 32'h0C0C0002);
    send(32'h0C0C0002);
    @(negedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    check_reset("midrst");
    tick();
    arst_n = 1'b1;
    start_load(1, 0);
    push_i(0, 32'h0D0D0001);
    send(32'h0D0D0001);
    expect_run("t5");
    // stop together with start in RUN
    start = 1'b1;
    stop = 1'b1;
    imem_count = 16'd5;
    tick();
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    check("ss_idle", {61'd0, cpu_enable, busy, in_ready}, 64'd0);
    tick();
    @(negedge clk);
    check("ss_start_ignored", {62'd0, busy, in_ready}, 64'd0);
    start_load(1, 1);
    push_i(0, 32'h0E0E0001);
    send(32'h0E0E0001);
    send(32'h55667788);
    push_d(0, 32'h11223344, 32'h55667788);
    send(32'h11223344);
    expect_run("t6");
    do_stop("t6");
    check("sb_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
